// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// funct3 codes, FSM states and the default watchdog limit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LSU_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and load extraction/extension.
// Purely combinational; funct3 codes outside B/H/BU/HU act as W.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_fmt,
  output logic        o_misaligned
);

  logic        w_b;
  logic        w_h;
  logic        w_sx;
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_b = (i_funct3 == F3_B) | (i_funct3 == F3_BU);
  assign w_h = (i_funct3 == F3_H) | (i_funct3 == F3_HU);
  assign w_sx = ~i_funct3[2];
  assign w_shift = i_rdata >> {i_addr, 3'b000};
  assign w_byte = w_shift[7:0];
  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be = 4'b1111;
    o_wdata = i_st_data;
    o_ld_fmt = i_rdata;
    o_misaligned = |i_addr;
    unique case (1'b1)
      w_b: begin
        o_be = 4'b0001 << i_addr;
        o_wdata = {4{i_st_data[7:0]}};
        o_ld_fmt = {{24{w_sx & w_byte[7]}}, w_byte};
        o_misaligned = 1'b0;
      end
      w_h: begin
        o_be = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_st_data[15:0]}};
        o_ld_fmt = {{16{w_sx & w_half[15]}}, w_half};
        o_misaligned = i_addr[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: req/ack data-memory FSM with stall.
// Define LSU_TIMEOUT_EN to enable the BUSY watchdog and bus_err_o.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       alu_out_in,
  input  logic [31:0]       st_data_in,
  output logic [31:0]       alu_out_out,
  output logic [31:0]       ld_data_out,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              bus_err_o
);

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_f3;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_ld;

  logic              w_mem_op;
  logic              w_idle;
  logic              w_issue;
  logic              w_ack;
  logic              w_to;
  logic [2:0]        w_f3;
  logic [1:0]        w_lane;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ld_fmt;
  logic              w_mis;

  assign w_mem_op = valid_in & (is_load | is_store);
  assign w_idle = (r_state == IDLE);

  // One aligner: live inputs in IDLE, latched access while BUSY.
  assign w_f3 = w_idle ? funct3 : r_f3;
  assign w_lane = w_idle ? alu_out_in[1:0] : r_addr[1:0];

  lsu_align u_align (
    .i_funct3    (w_f3),
    .i_addr      (w_lane),
    .i_st_data   (st_data_in),
    .i_rdata     (dm_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_ld_fmt    (w_ld_fmt),
    .o_misaligned(w_mis)
  );

  assign w_issue = w_idle & w_mem_op & ~w_mis;
  assign w_ack = (r_state == BUSY) & dm_ack;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_bus_err;

  assign w_to = (r_state == BUSY) & ~dm_ack &
                (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_to;
      if (w_issue) r_cnt <= '0;
      else if (r_state == BUSY && !dm_ack) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus_err_o = r_bus_err;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES == 0);
  assign w_to = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_f3 <= '0;
      r_we <= 1'b0;
      r_be <= '0;
      r_wdata <= '0;
      r_ld <= '0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_addr <= alu_out_in[ADDR_W-1:0];
        r_f3 <= funct3;
        r_we <= is_store;
        r_be <= w_be;
        r_wdata <= w_wdata;
        r_ld <= '0;
      end
      if (w_ack) r_ld <= r_we ? '0 : w_ld_fmt;
    end
  end

  always_comb begin
    w_next = r_state;
    stall_o = 1'b0;
    dm_req = 1'b0;
    ld_data_out = '0;
    misalign_o = 1'b0;
    unique case (r_state)
      IDLE: begin
        stall_o = w_issue;
        misalign_o = ~rst & w_mem_op & w_mis;
        if (w_issue) w_next = BUSY;
      end
      BUSY: begin
        stall_o = 1'b1;
        dm_req = 1'b1;
        if (dm_ack | w_to) w_next = DONE;
      end
      DONE: begin
        ld_data_out = r_ld;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign alu_out_out = alu_out_in;
  assign dm_we = r_we;
  assign dm_be = r_be;
  assign dm_wdata = r_wdata;
  assign dm_addr = {r_addr[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu.
// Build with LSU_TIMEOUT_EN to exercise the watchdog path.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] alu_out_in;
  logic [31:0] st_data_in;
  logic [31:0] alu_out_out;
  logic [31:0] ld_data_out;
  logic        stall_o;
  logic        misalign_o;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        bus_err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_lsu #(
    .ADDR_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .is_load(is_load),
    .is_store(is_store),
    .funct3(funct3),
    .alu_out_in(alu_out_in),
    .st_data_in(st_data_in),
    .alu_out_out(alu_out_out),
    .ld_data_out(ld_data_out),
    .stall_o(stall_o),
    .misalign_o(misalign_o),
    .dm_req(dm_req),
    .dm_we(dm_we),
    .dm_addr(dm_addr),
    .dm_be(dm_be),
    .dm_wdata(dm_wdata),
    .dm_ack(dm_ack),
    .dm_rdata(dm_rdata),
    .bus_err_o(bus_err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid_in = 1'b0;
    is_load = 1'b0;
    is_store = 1'b0;
    funct3 = 3'b000;
    alu_out_in = 32'h0;
    st_data_in = 32'h0;
    dm_ack = 1'b0;
    dm_rdata = 32'h0;
  endtask

  task automatic issue(input logic ld, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    valid_in = 1'b1;
    is_load = ld;
    is_store = ~ld;
    funct3 = f3;
    alu_out_in = a;
    st_data_in = sd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    step();
    step();
    checks++;
    if ({dm_req, dm_we, dm_be} !== 6'b0) begin
      failures++;
      $display("FAIL rst_ctrl got=%b exp=0", {dm_req, dm_we, dm_be});
    end
    checks++;
    if ({dm_addr, dm_wdata, ld_data_out} !== 96'h0) begin
      failures++;
      $display("FAIL rst_data got=%h exp=0",
               {dm_addr, dm_wdata, ld_data_out});
    end
    checks++;
    if ({stall_o, misalign_o, bus_err_o} !== 3'b000) begin
      failures++;
      $display("FAIL rst_flags got=%b exp=000",
               {stall_o, misalign_o, bus_err_o});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_lw();
    issue(1'b1, 3'b010, 32'h100, 32'h0);
    #1;
    checks++;
    if ({stall_o, dm_req} !== 2'b10) begin
      failures++;
      $display("FAIL lw_idle got=%b exp=10", {stall_o, dm_req});
    end
    checks++;
    if (alu_out_out !== 32'h100) begin
      failures++;
      $display("FAIL lw_pass got=%h exp=100", alu_out_out);
    end
    step();
    checks++;
    if ({stall_o, dm_req, dm_we, dm_be} !== 7'b1101111) begin
      failures++;
      $display("FAIL lw_busy got=%b exp=1101111",
               {stall_o, dm_req, dm_we, dm_be});
    end
    checks++;
    if (dm_addr !== 32'h100) begin
      failures++;
      $display("FAIL lw_addr got=%h exp=100", dm_addr);
    end
    dm_ack = 1'b1;
    dm_rdata = 32'hDEADBEEF;
    step();
    idle_in();
    #1;
    checks++;
    if ({stall_o, dm_req} !== 2'b00 || ld_data_out !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL lw_done got=%b/%h exp=00/deadbeef",
               {stall_o, dm_req}, ld_data_out);
    end
    step();
    checks++;
    if (ld_data_out !== 32'h0 || dm_req !== 1'b0) begin
      failures++;
      $display("FAIL lw_idle_after got=%h/%b exp=0/0",
               ld_data_out, dm_req);
    end
  endtask

  task automatic test_load_fmt();
    logic [2:0]  f3  [6];
    logic [31:0] ad  [6];
    logic [31:0] ex  [6];
    f3 = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b011};
    ad = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h104};
    ex = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011,
           32'h00002233, 32'h00000022, 32'h80112233};
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, f3[i], ad[i], 32'h0);
      step();
      dm_ack = 1'b1;
      dm_rdata = 32'h80112233;
      step();
      idle_in();
      #1;
      checks++;
      if (ld_data_out !== ex[i]) begin
        failures++;
        $display("FAIL ld_fmt%0d got=%h exp=%h", i, ld_data_out, ex[i]);
      end
      step();
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3 [4];
    logic [31:0] ad [4];
    logic [31:0] sd [4];
    logic [3:0]  eb [4];
    logic [31:0] ew [4];
    logic [31:0] ea [4];
    f3 = '{3'b001, 3'b000, 3'b010, 3'b001};
    ad = '{32'h102, 32'h101, 32'h208, 32'h100};
    sd = '{32'h0000ABCD, 32'h12345678, 32'hCAFEF00D, 32'h1234ABCD};
    eb = '{4'b1100, 4'b0010, 4'b1111, 4'b0011};
    ew = '{32'hABCDABCD, 32'h78787878, 32'hCAFEF00D, 32'hABCDABCD};
    ea = '{32'h100, 32'h100, 32'h208, 32'h100};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3[i], ad[i], sd[i]);
      step();
      checks++;
      if ({dm_req, dm_we, dm_be} !== {2'b11, eb[i]}) begin
        failures++;
        $display("FAIL st_be%0d got=%b exp=11%b",
                 i, {dm_req, dm_we, dm_be}, eb[i]);
      end
      checks++;
      if (dm_wdata !== ew[i] || dm_addr !== ea[i]) begin
        failures++;
        $display("FAIL st_data%0d got=%h/%h exp=%h/%h",
                 i, dm_wdata, dm_addr, ew[i], ea[i]);
      end
      dm_ack = 1'b1;
      dm_rdata = 32'hFFFFFFFF;
      step();
      idle_in();
      #1;
      checks++;
      if (ld_data_out !== 32'h0 || stall_o !== 1'b0) begin
        failures++;
        $display("FAIL st_done%0d got=%h/%b exp=0/0",
                 i, ld_data_out, stall_o);
      end
      step();
    end
  endtask

  task automatic test_misalign();
    logic        ld [3];
    logic [2:0]  f3 [3];
    logic [31:0] ad [3];
    ld = '{1'b1, 1'b0, 1'b1};
    f3 = '{3'b010, 3'b001, 3'b010};
    ad = '{32'h101, 32'h103, 32'h102};
    for (int i = 0; i < 3; i++) begin
      issue(ld[i], f3[i], ad[i], 32'h55);
      #1;
      checks++;
      if ({misalign_o, stall_o, dm_req} !== 3'b100 ||
          ld_data_out !== 32'h0) begin
        failures++;
        $display("FAIL mis%0d got=%b/%h exp=100/0",
                 i, {misalign_o, stall_o, dm_req}, ld_data_out);
      end
      step();
      idle_in();
      #1;
      checks++;
      if ({misalign_o, stall_o, dm_req} !== 3'b000) begin
        failures++;
        $display("FAIL mis_after%0d got=%b exp=000",
                 i, {misalign_o, stall_o, dm_req});
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 3'b010, 32'h200, 32'h0);
    step();
    step();
    step();
    checks++;
    if ({dm_req, stall_o} !== 2'b11 || dm_addr !== 32'h200) begin
      failures++;
      $display("FAIL rmid_busy got=%b/%h exp=11/200",
               {dm_req, stall_o}, dm_addr);
    end
    rst = 1'b1;
    idle_in();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({dm_req, stall_o} !== 2'b00 || dm_addr !== 32'h0) begin
      failures++;
      $display("FAIL rmid_abort got=%b/%h exp=00/0",
               {dm_req, stall_o}, dm_addr);
    end
    step();
    dm_ack = 1'b1;
    dm_rdata = 32'h12345678;
    step();
    idle_in();
    #1;
    checks++;
    if ({dm_req, stall_o} !== 2'b00 || ld_data_out !== 32'h0) begin
      failures++;
      $display("FAIL rmid_late_ack got=%b/%h exp=00/0",
               {dm_req, stall_o}, ld_data_out);
    end
    step();
    checks++;
    if (ld_data_out !== 32'h0 || dm_req !== 1'b0) begin
      failures++;
      $display("FAIL rmid_idle got=%h/%b exp=0/0", ld_data_out, dm_req);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 3'b010, 32'h10, 32'h0);
    step();
    dm_ack = 1'b1;
    dm_rdata = 32'h0BADF00D;
    step();
    dm_ack = 1'b0;
    issue(1'b0, 3'b010, 32'h14, 32'h11223344);
    #1;
    checks++;
    if ({stall_o, dm_req} !== 2'b00 || ld_data_out !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL b2b_done got=%b/%h exp=00/0badf00d",
               {stall_o, dm_req}, ld_data_out);
    end
    step();
    checks++;
    if ({stall_o, dm_req} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_idle got=%b exp=10", {stall_o, dm_req});
    end
    step();
    checks++;
    if ({dm_req, dm_we} !== 2'b11 || dm_addr !== 32'h14 ||
        dm_wdata !== 32'h11223344) begin
      failures++;
      $display("FAIL b2b_st got=%b/%h/%h exp=11/14/11223344",
               {dm_req, dm_we}, dm_addr, dm_wdata);
    end
    dm_ack = 1'b1;
    step();
    idle_in();
    step();
  endtask

  task automatic test_timeout();
    issue(1'b1, 3'b010, 32'h300, 32'h0);
    step();
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({dm_req, bus_err_o} !== 2'b10) begin
        failures++;
        $display("FAIL to_busy%0d got=%b exp=10", i, {dm_req, bus_err_o});
      end
      step();
    end
    idle_in();
    #1;
    checks++;
    if ({bus_err_o, dm_req, stall_o} !== 3'b100 ||
        ld_data_out !== 32'h0) begin
      failures++;
      $display("FAIL to_err got=%b/%h exp=100/0",
               {bus_err_o, dm_req, stall_o}, ld_data_out);
    end
    step();
    checks++;
    if ({bus_err_o, dm_req, stall_o} !== 3'b000) begin
      failures++;
      $display("FAIL to_idle got=%b exp=000",
               {bus_err_o, dm_req, stall_o});
    end
`else
    for (int i = 0; i < 8; i++) step();
    checks++;
    if ({dm_req, stall_o, bus_err_o} !== 3'b110) begin
      failures++;
      $display("FAIL to_wait got=%b exp=110",
               {dm_req, stall_o, bus_err_o});
    end
    rst = 1'b1;
    idle_in();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({dm_req, bus_err_o} !== 2'b00) begin
      failures++;
      $display("FAIL to_rst got=%b exp=00", {dm_req, bus_err_o});
    end
`endif
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    test_reset();
    test_lw();
    test_load_fmt();
    test_store();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
